// File: rtl/fifo_burst_ctrl.sv
// Burst read controller: pulls BURST words from a registered-output FIFO and
// hands them downstream one at a time. Define BURST_TIMEOUT_EN to enable partial-burst flush.
module fifo_burst_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable_i,
    input  logic                       fifo_wr_en_i,
    input  logic                       fifo_full_i,
    input  logic                       fifo_empty_i,
    output logic                       fifo_rd_en_o,
    input  logic [WIDTH-1:0]           fifo_read_data_i,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [WIDTH-1:0]           m_data_o,
    output logic                       m_last_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       busy_o
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] BURST_L = LW'(BURST);
    localparam logic [LW-1:0] MAX_L   = LW'(DEPTH - 1);
    // An out-of-range parameter set never starts a burst rather than misbehaving.
    localparam bit CFG_OK = (BURST >= 1) && (BURST < DEPTH) && (TIMEOUT >= 1);

    typedef enum logic [1:0] {IDLE, READ, CAPTURE, OUTPUT} state_e;

    state_e            state_q, state_d;
    logic [LW-1:0]     level_q, level_d;
    logic [LW-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              last_q, last_d;
    logic              rd_en;
    logic              inc, dec;
    logic              start_full;
    logic              start_part;

    assign rd_en      = (state_q == READ) && !fifo_empty_i;
    assign inc        = fifo_wr_en_i && !fifo_full_i;
    assign dec        = rd_en && !fifo_empty_i;
    assign start_full = CFG_OK && enable_i && (level_q >= BURST_L);

`ifdef BURST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_cond;

    // Counts consecutive idle cycles holding a stranded partial burst; any gap restarts it.
    always_comb begin
        tmo_cond   = (state_q == IDLE) && enable_i && (level_q != '0) && (level_q < BURST_L);
        tmo_d      = '0;
        start_part = 1'b0;
        if (tmo_cond) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                start_part = CFG_OK;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign start_part = 1'b0;
`endif

    always_comb begin
        level_d = level_q;
        if (inc && !dec && (level_q < MAX_L)) begin
            level_d = level_q + 1'b1;
        end else if (dec && !inc && (level_q != '0)) begin
            level_d = level_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (start_full) begin
                    state_d = READ;
                    rem_d   = BURST_L;
                    last_d  = 1'b0;
                end else if (start_part) begin
                    state_d = READ;
                    rem_d   = level_q;
                    last_d  = 1'b0;
                end
            end
            READ: begin
                // An empty FIFO here is an upstream fault; wait it out.
                if (!fifo_empty_i) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                data_d  = fifo_read_data_i;
                rem_d   = rem_q - 1'b1;
                last_d  = (rem_q == LW'(1));
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (m_ready_i) begin
                    state_d = (rem_q != '0) ? READ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            level_q <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign fifo_rd_en_o = rd_en;
    assign m_valid_o    = (state_q == OUTPUT);
    assign m_data_o     = data_q;
    assign m_last_o     = last_q;
    assign level_o      = level_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_burst_ctrl.sv
// Testbench for fifo_burst_ctrl: a queue-based FIFO model feeds the DUT and a
// stream-level reference predicts burst starts, word order, last flags and level.
module tb_fifo_burst_ctrl;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 8;
    localparam int BURST   = 4;
    localparam int TIMEOUT = 64;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              enable_i;
    logic              fifo_wr_en_i;
    logic              fifo_full_i;
    logic              fifo_empty_i;
    logic              fifo_rd_en_o;
    logic [WIDTH-1:0]  fifo_read_data_i;
    logic              m_valid_o;
    logic              m_ready_i;
    logic [WIDTH-1:0]  m_data_o;
    logic              m_last_o;
    logic [LW-1:0]     level_o;
    logic              busy_o;

    fifo_burst_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .BURST(BURST), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .fifo_wr_en_i(fifo_wr_en_i),
        .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
        .fifo_rd_en_o(fifo_rd_en_o), .fifo_read_data_i(fifo_read_data_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
        .m_last_o(m_last_o), .level_o(level_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Environment FIFO contents and the expected downstream word stream.
    logic [WIDTH-1:0] fifo_m[$];
    logic [WIDTH-1:0] wr_log[$];
    logic [WIDTH-1:0] s_wdata;
    bit  s_wr, s_rd, s_hs, s_idle, s_start, prev_valid;
    int  s_len, burst_len, word_idx, tmo_m;
    int  cyc, rd_cyc, rd_cnt, hs_cnt;

    task automatic clear_model();
        fifo_m.delete();
        wr_log.delete();
        s_wr = 0; s_rd = 0; s_hs = 0; s_idle = 0; s_start = 0; prev_valid = 0;
        s_len = 0; burst_len = 0; word_idx = 0; tmo_m = 0;
        rd_cnt = 0; hs_cnt = 0; rd_cyc = 0;
    endtask

    task automatic drive_quiet();
        enable_i = 0; fifo_wr_en_i = 0; fifo_full_i = 0; fifo_empty_i = 1;
        m_ready_i = 0; fifo_read_data_i = '0;
    endtask

    task automatic cycle(input bit wr, input bit en, input bit rdy);
        @(negedge clk);
        cyc++;
        // Apply what happened at the edge just passed.
        if (s_rd && fifo_m.size() > 0) begin
            fifo_read_data_i = fifo_m.pop_front();
            rd_cnt++;
        end
        if (s_wr) begin
            fifo_m.push_back(s_wdata);
            wr_log.push_back(s_wdata);
        end
        if (s_hs) begin
            if (wr_log.size() > 0) void'(wr_log.pop_front());
            word_idx++;
            hs_cnt++;
        end
        // Compare against expectations.
        chk("level", int'(level_o), fifo_m.size());
        if (s_idle) begin
            chk("burst_start", int'(busy_o), int'(s_start));
            if (s_start) begin
                burst_len = s_len;
                word_idx  = 0;
            end
        end
        if (s_hs) chk("busy_after_hs", int'(busy_o), int'(word_idx < burst_len));
        if (m_valid_o) begin
            chk("data", int'(m_data_o), (wr_log.size() > 0) ? int'(wr_log[0]) : -1);
            chk("last", int'(m_last_o), int'(word_idx == burst_len - 1));
            if (!prev_valid) chk("latency", cyc - rd_cyc, 2);
        end
        prev_valid = m_valid_o;
        // Drive the next edge.
        fifo_full_i  = (fifo_m.size() == DEPTH - 1);
        fifo_empty_i = (fifo_m.size() == 0);
        fifo_wr_en_i = wr;
        enable_i     = en;
        m_ready_i    = rdy;
        s_wr    = wr && !fifo_full_i;
        s_wdata = WIDTH'($urandom);
        s_idle  = !busy_o;
        s_hs    = m_valid_o && rdy;
        s_start = 0;
        if (s_idle && en && int'(level_o) >= BURST) begin
            s_start = 1;
            s_len   = BURST;
        end
`ifdef BURST_TIMEOUT_EN
        if (s_idle && en && level_o != 0 && int'(level_o) < BURST) begin
            if (tmo_m + 1 == TIMEOUT) begin
                s_start = 1;
                s_len   = int'(level_o);
                tmo_m   = 0;
            end else begin
                tmo_m++;
            end
        end else begin
            tmo_m = 0;
        end
`endif
        #1;
        s_rd = fifo_rd_en_o && !fifo_empty_i;
        if (fifo_rd_en_o) begin
            chk("rd_while_empty", int'(fifo_empty_i), 0);
            chk("reads_outstanding", rd_cnt - hs_cnt, 0);
            rd_cyc = cyc;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst = 1;
        #1;
        chk("rst_rd_en", int'(fifo_rd_en_o), 0);
        chk("rst_valid", int'(m_valid_o), 0);
        chk("rst_last", int'(m_last_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_data", int'(m_data_o), 0);
        chk("rst_level", int'(level_o), 0);
        @(negedge clk);
        clear_model();
        drive_quiet();
        @(negedge clk);
        rst = 0;
    endtask

    int h0;
    bit seen;

    initial begin
        cyc = 0;
        rst = 0;
        clear_model();
        drive_quiet();
        #1 rst = 1;
        #1;
        chk("init_busy", int'(busy_o), 0);
        chk("init_level", int'(level_o), 0);
        chk("init_valid", int'(m_valid_o), 0);
        chk("init_rd_en", int'(fifo_rd_en_o), 0);
        repeat (2) @(negedge clk);
        rst = 0;

        // Full burst, free-flowing downstream.
        h0 = hs_cnt;
        repeat (4) cycle(1, 0, 1);
        repeat (20) cycle(0, 1, 1);
        chk("burst_words", hs_cnt - h0, 4);

        // Downstream stalls with data held.
        h0 = hs_cnt;
        repeat (4) cycle(1, 0, 1);
        for (int i = 0; i < 30; i++) cycle(0, 1, i >= 14);
        chk("stall_words", hs_cnt - h0, 4);

        // Write coinciding with the read strobe at level 4.
        repeat (4) cycle(1, 0, 1);
        cycle(0, 1, 1);
        cycle(1, 0, 1);
        cycle(0, 0, 1);
        chk("wr_rd_level", int'(level_o), 4);
        repeat (20) cycle(0, 0, 1);

        // Enable dropped right after start: exactly one burst.
        h0 = hs_cnt;
        repeat (6) cycle(1, 0, 1);
        cycle(0, 1, 1);
        repeat (30) cycle(0, 0, 1);
        chk("enable_drop_words", hs_cnt - h0, 4);
        chk("enable_drop_level", int'(level_o), 3);

        // Stranded partial burst with enable held.
        pulse_reset();
        h0 = hs_cnt;
        repeat (2) cycle(1, 0, 1);
        repeat (90) cycle(0, 1, 1);
`ifdef BURST_TIMEOUT_EN
        chk("partial_words", hs_cnt - h0, 2);
`else
        chk("partial_words", hs_cnt - h0, 0);
`endif

        // Reset landing in CAPTURE.
        pulse_reset();
        repeat (4) cycle(1, 0, 1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle(0, 1, 1);
            seen = s_rd;
        end
        chk("capture_reached", int'(seen), 1);
        pulse_reset();
        repeat (3) cycle(0, 0, 1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) pulse_reset();
            cycle(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
        end
        repeat (40) cycle(0, 0, 1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
